reg_file_2r1w: RTL and testbench

- Parametrised register file with two synchronous read ports, one write port and a per-register busy scoreboard.
- Sits between decode and writeback of the core datapath. Decode reads both source operands and reserves the destination register. Writeback writes the result and releases the reservation.
- Contents are initialised by reset only. There is no file-based load or dump.

---
 rtl/reg_file_pkg.sv | 14 +
 rtl/reg_file_2r1w_scoreboard.sv | 56 +++++
 rtl/reg_file_2r1w.sv | 131 +++++++++++++
 tb/tb_reg_file_2r1w.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the two-read/one-write register file and its
// reservation scoreboard.
package reg_file_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 32;
    localparam int DEFAULT_ADDR_W   = $clog2(DEFAULT_NUM_REGS);

    localparam logic [DEFAULT_ADDR_W-1:0] ZERO_ADDR = '0;

    typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_2r1w_scoreboard.sv
// Per-register busy scoreboard: decode reserves a destination, writeback
// releases it. A same-cycle reserve of the written register wins.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic                rsv_en,
    input  logic [ADDR_W-1:0]   rsv_addr,
    output logic                rsv_ready,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                wr_hits_rsv;
    logic                rsv_is_zero;

    // A write landing on the same edge frees the slot, so a pending
    // reservation can be re-issued without a bubble.
    always_comb begin
        wr_hits_rsv = wr_en && (wr_addr == rsv_addr);
        rsv_is_zero = ZERO_REG && (rsv_addr == ADDR_W'(ZERO_ADDR));
        rsv_ready   = rsv_is_zero || !busy_q[rsv_addr] || wr_hits_rsv;
    end

    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_en && rsv_ready) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Two synchronous read ports, one write port, reservation scoreboard.
// Define REG_FILE_BYPASS_EN for write-first read/write collisions (default read-first).
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rs1_addr,
    input  logic [ADDR_W-1:0]   rs2_addr,
    output logic [DATA_W-1:0]   rs1_data,
    output logic [DATA_W-1:0]   rs2_data,
    output logic                rd_valid,
    output logic                rs1_busy,
    output logic                rs2_busy,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rsv_en,
    input  logic [ADDR_W-1:0]   rsv_addr,
    output logic                rsv_ready,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
    logic              rs1_busy_q, rs1_busy_d;
    logic              rs2_busy_q, rs2_busy_d;
    logic              rd_valid_q, rd_valid_d;

    logic wr_is_zero;
    logic rs1_is_zero;
    logic rs2_is_zero;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .busy_vec  (busy_vec)
    );

    always_comb begin
        wr_is_zero  = ZERO_REG && (wr_addr  == ADDR_W'(ZERO_ADDR));
        rs1_is_zero = ZERO_REG && (rs1_addr == ADDR_W'(ZERO_ADDR));
        rs2_is_zero = ZERO_REG && (rs2_addr == ADDR_W'(ZERO_ADDR));
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en && !wr_is_zero) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Read outputs hold their last values while rd_en is low.
    always_comb begin
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rs1_busy_d = rs1_busy_q;
        rs2_busy_d = rs2_busy_q;
        rd_valid_d = rd_en;
        if (rd_en) begin
            rs1_data_d = regs_q[rs1_addr];
            rs2_data_d = regs_q[rs2_addr];
            rs1_busy_d = busy_vec[rs1_addr];
            rs2_busy_d = busy_vec[rs2_addr];
`ifdef REG_FILE_BYPASS_EN
            if (wr_en && (wr_addr == rs1_addr)) begin
                rs1_data_d = wr_data;
                rs1_busy_d = 1'b0;
            end
            if (wr_en && (wr_addr == rs2_addr)) begin
                rs2_data_d = wr_data;
                rs2_busy_d = 1'b0;
            end
`endif
            // Register 0 is applied last so it overrides any bypass.
            if (rs1_is_zero) begin
                rs1_data_d = '0;
                rs1_busy_d = 1'b0;
            end
            if (rs2_is_zero) begin
                rs2_data_d = '0;
                rs2_busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rs1_busy_q <= 1'b0;
            rs2_busy_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rs1_busy_q <= rs1_busy_d;
            rs2_busy_q <= rs2_busy_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rs1_data = rs1_data_q;
    assign rs2_data = rs2_data_q;
    assign rs1_busy = rs1_busy_q;
    assign rs2_busy = rs2_busy_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: read expectations are queued at issue and
// compared when rd_valid returns; control-path checks are inline per scenario.
module tb_reg_file_2r1w;
    import reg_file_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        rd_en;
    reg_addr_t   rs1_addr, rs2_addr;
    reg_data_t   rs1_data, rs2_data;
    logic        rd_valid, rs1_busy, rs2_busy;
    logic        wr_en;
    reg_addr_t   wr_addr;
    reg_data_t   wr_data;
    logic        rsv_en;
    reg_addr_t   rsv_addr;
    logic        rsv_ready;
    logic [31:0] busy_vec;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
    } rd_exp_t;

    rd_exp_t     exp_q[$];
    logic [31:0] model_regs [32];
    logic [31:0] model_busy;
    int          checks;
    int          errors;

    reg_file_2r1w dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rd_valid  (rd_valid),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .busy_vec  (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read results are compared at the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            rd_exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got rd_valid=1 need no pending read");
            end else begin
                e = exp_q.pop_front();
                if ({rs1_data, rs2_data, rs1_busy, rs2_busy} !== e) begin
                    errors++;
                    $display("FAIL rd_result got d1=%h d2=%h b1=%b b2=%b need d1=%h d2=%h b1=%b b2=%b",
                             rs1_data, rs2_data, rs1_busy, rs2_busy, e.d1, e.d2, e.b1, e.b2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout need completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_en = 0; wr_en = 0; rsv_en = 0;
        rs1_addr = '0; rs2_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
    endtask

    task automatic issue_read(input int a1, input int a2);
        rd_exp_t e;
        rd_en    = 1;
        rs1_addr = reg_addr_t'(a1);
        rs2_addr = reg_addr_t'(a2);
        e.d1 = (a1 == 0) ? 32'h0 : model_regs[a1];
        e.d2 = (a2 == 0) ? 32'h0 : model_regs[a2];
        e.b1 = (a1 == 0) ? 1'b0 : model_busy[a1];
        e.b2 = (a2 == 0) ? 1'b0 : model_busy[a2];
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && wr_addr == reg_addr_t'(a1) && a1 != 0) begin e.d1 = wr_data; e.b1 = 0; end
        if (wr_en && wr_addr == reg_addr_t'(a2) && a2 != 0) begin e.d2 = wr_data; e.b2 = 0; end
`endif
        exp_q.push_back(e);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        model_busy = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        step(); step();
        rst_n = 1;
        clear_model();
        checks++;
        if (busy_vec !== 32'h0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got busy_vec=%h rd_valid=%b need 0 0", busy_vec, rd_valid);
        end
        checks++;
        if ({rs1_data, rs2_data, rs1_busy, rs2_busy} !== 66'h0) begin
            errors++;
            $display("FAIL reset_data got d1=%h d2=%h b1=%b b2=%b need all 0",
                     rs1_data, rs2_data, rs1_busy, rs2_busy);
        end
        issue_read(5, 31);
        step();
        rd_en = 0;
        step();
    endtask

    task automatic test_write_read();
        wr_en = 1; wr_addr = 7; wr_data = 32'hDEADBEEF;
        step();
        model_regs[7] = 32'hDEADBEEF;
        wr_en = 0;
        issue_read(7, 7);
        step();
        rd_en = 0;
        step();
        checks++;
        if (rd_valid !== 1'b0 || rs1_data !== 32'hDEADBEEF || rs2_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL idle_hold got rd_valid=%b d1=%h d2=%h need 0 deadbeef deadbeef",
                     rd_valid, rs1_data, rs2_data);
        end
    endtask

    task automatic test_zero_reg();
        wr_en = 1; wr_addr = 0; wr_data = 32'h1234;
        step();
        wr_en = 0;
        rsv_en = 1; rsv_addr = 0;
        #1;
        checks++;
        if (rsv_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_rsv_ready got %b need 1", rsv_ready);
        end
        step();
        rsv_en = 0;
        checks++;
        if (busy_vec[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_busy got %b need 0", busy_vec[0]);
        end
        issue_read(0, 0);
        step();
        rd_en = 0;
        step();
    endtask

    task automatic test_reserve();
        rsv_en = 1; rsv_addr = 3;
        #1;
        checks++;
        if (rsv_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsv_first_ready got %b need 1", rsv_ready);
        end
        step();
        model_busy[3] = 1;
        checks++;
        if (busy_vec !== 32'h0000_0008) begin
            errors++;
            $display("FAIL rsv_set got busy_vec=%h need 00000008", busy_vec);
        end
        checks++;
        if (rsv_ready !== 1'b0) begin
            errors++;
            $display("FAIL rsv_stall got rsv_ready=%b need 0", rsv_ready);
        end
        step();
        wr_en = 1; wr_addr = 3; wr_data = 32'hA5;
        #1;
        checks++;
        if (rsv_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsv_wr_ready got %b need 1", rsv_ready);
        end
        step();
        model_regs[3] = 32'hA5;
        wr_en = 0; rsv_en = 0;
        checks++;
        if (busy_vec !== 32'h0000_0008) begin
            errors++;
            $display("FAIL rsv_wins got busy_vec=%h need 00000008", busy_vec);
        end
        issue_read(3, 7);
        step();
        rd_en = 0;
        wr_en = 1; wr_addr = 3; wr_data = 32'hA5;
        step();
        model_busy[3] = 0;
        wr_en = 0;
        checks++;
        if (busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL wr_clear got busy_vec=%h need 00000000", busy_vec);
        end
    endtask

    task automatic test_collision();
        wr_en = 1; wr_addr = 9; wr_data = 32'h11;
        step();
        model_regs[9] = 32'h11;
        wr_en = 0;
        rsv_en = 1; rsv_addr = 9;
        step();
        model_busy[9] = 1;
        rsv_en = 0;
        wr_en = 1; wr_addr = 9; wr_data = 32'h22;
        issue_read(9, 9);
        step();
        model_regs[9] = 32'h22;
        model_busy[9] = 0;
        wr_en = 0;
        checks++;
        if (busy_vec[9] !== 1'b0) begin
            errors++;
            $display("FAIL collide_busy got %b need 0", busy_vec[9]);
        end
        issue_read(9, 3);
        step();
        rd_en = 0;
        step();
    endtask

    task automatic test_reset_mid();
        rsv_en = 1; rsv_addr = 4;
        wr_en = 1; wr_addr = 10; wr_data = 32'h55;
        step();
        model_busy[4] = 1;
        model_regs[10] = 32'h55;
        rsv_en = 0; wr_en = 0;
        checks++;
        if (busy_vec !== 32'h0000_0010) begin
            errors++;
            $display("FAIL mid_rsv got busy_vec=%h need 00000010", busy_vec);
        end
        issue_read(10, 4);
        step();
        rst_n = 0;
        rd_en = 1; rs1_addr = 10; rs2_addr = 4;
        wr_en = 1; wr_addr = 4; wr_data = 32'h77;
        rsv_en = 1; rsv_addr = 5;
        step();
        idle_inputs();
        rst_n = 1;
        clear_model();
        checks++;
        if (busy_vec !== 32'h0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ctrl got busy_vec=%h rd_valid=%b need 0 0", busy_vec, rd_valid);
        end
        checks++;
        if ({rs1_data, rs2_data, rs1_busy, rs2_busy} !== 66'h0) begin
            errors++;
            $display("FAIL mid_reset_data got d1=%h d2=%h b1=%b b2=%b need all 0",
                     rs1_data, rs2_data, rs1_busy, rs2_busy);
        end
        issue_read(10, 4);
        step();
        rd_en = 0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_model();
        test_reset();
        test_write_read();
        test_zero_reg();
        test_reserve();
        test_collision();
        test_reset_mid();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rd_missing got %0d pending reads need 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
